alu_write_back: RTL and testbench
=================================

Name: alu_write_back

Overview:
- Downstream of the ALU: consumes one 64-pixel ALU result block per handshake.
- Either overwrites or accumulates the block into an internal 64-word buffer. Accumulation is used for convolution partial sums across input channels and for gram/dot-product partials.
- When a group is complete, streams the first N words out as single 32-bit DDR3 write beats at consecutive word addresses.

Parameters:
- N_PIX, 64, pixels per ALU result block (buffer depth)
- DW, 32, pixel/word width in bits (signed two's complement)
- AW, 27, DDR3 word address width

Ports:
- iCLK  in  1  clock; all state changes on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iVALID  in  1  ALU result valid
- oREADY  out  1  block can accept a result this cycle
- iDATA  in  N_PIX*DW  result block; pixel k at bits [k*DW +: DW]
- iACCUM  in  1  1 = add to buffer, 0 = overwrite buffer
- iLAST  in  1  last beat of group; flush after capture
- iCOUNT  in  7  words to flush (0..64; 64 for full block, 16 for pool)
- iBASE_ADDR  in  AW  DDR3 word address of flushed word 0
- oWR_VALID  out  1  write beat valid
- iWR_READY  in  1  DDR3 side accepts beat
- oWR_ADDR  out  AW  write address
- oWR_DATA  out  DW  write data
- oBUSY  out  1  high while not IDLE
- oDONE  out  1  one-cycle pulse, flush complete

Behaviour:
- Reset (async assert, sync release): state=IDLE; oREADY=1 once out of reset; oWR_VALID=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, oDONE=0; word index=0. Buffer contents undefined after reset.
- States:
  - IDLE: oREADY=1.
    - On iVALID&oREADY, at that edge: for each lane k, buf[k] <= iACCUM ? buf[k]+iDATA[k] : iDATA[k]. All N_PIX lanes are updated regardless of iCOUNT.
    - If iLAST=0: stay in IDLE. Back-to-back accumulates are allowed every cycle.
    - If iLAST=1: latch iCOUNT and iBASE_ADDR, index<=0, then:
      - iCOUNT!=0: go to FLUSH.
      - iCOUNT==0: go to DONE.
  - FLUSH: oREADY=0, oBUSY=1.
    - oWR_VALID=1, oWR_ADDR=base+index, oWR_DATA=buf[index].
    - First beat is visible in the cycle after the iLAST handshake.
    - On iWR_READY: index++.
    - If the accepted beat is index==count-1: go to DONE.
    - Addr/data stay stable while oWR_VALID&!iWR_READY; oWR_VALID never drops mid-stream.
    - Address arithmetic is modulo 2^AW (wraps silently).
  - DONE: oWR_VALID=0, oDONE=1 for exactly one cycle, oBUSY=1; go to IDLE.
- Throughput: one write beat per cycle when iWR_READY=1. A group with count C takes C+1 cycles from the first FLUSH cycle to the oDONE cycle inclusive.
- Arithmetic: DW-bit signed add, wrap on overflow (default).
- iCOUNT>64 is treated as 64.
- iVALID while oREADY=0 is not accepted; upstream holds it.
- Simultaneous iVALID and DONE: not accepted that cycle; accepted the next cycle in IDLE.
- Reset mid-FLUSH: all outputs drop to reset values immediately. Unwritten words are lost; no oDONE.

Optional Feature:
- Macro: ALU_WB_SATURATE_EN.
- Defined: accumulation saturates to [-2^(DW-1), 2^(DW-1)-1]. Overwrite (iACCUM=0) is unaffected.
- Undefined: plain wrapping add.

Test Plan:
- Overwrite, single beat: lane k=k, iACCUM=0, iLAST=1, iCOUNT=64, iBASE_ADDR=0x100, iWR_READY=1 -> 64 beats on consecutive cycles, addr 0x100..0x13F, data 0..63; oDONE one cycle after the last beat; oREADY=1 the following cycle.
- Accumulate group: all lanes 5 (iACCUM=0), then 7 (iACCUM=1), then -2 (iACCUM=1, iLAST=1), back-to-back, iCOUNT=64 -> every written word = 10.
- Backpressure: iWR_READY pattern 1,0,0,1,0,1... during flush of data 0..63 -> addr/data held stable during stalls; exactly 64 unique beats in order; no duplicates or drops.
- Pool count: iCOUNT=16, base 0x2000 -> exactly 16 beats at 0x2000..0x200F, then oDONE.
- iCOUNT=0 with iLAST=1 -> no oWR_VALID; oDONE one cycle after the handshake.
- Overflow: 0x7FFFFFFF then accumulate 1 -> 0x80000000 without the macro, 0x7FFFFFFF with ALU_WB_SATURATE_EN.
- Reset: assert iRST after 10 of 64 beats accepted -> oWR_VALID=0 the same cycle (async), no oDONE; after release, a new single-beat group flushes correctly.

Source files
------------

// File: rtl/alu_write_back.sv
// alu_write_back: ALU result write-back stage.
// Captures 64-lane ALU result blocks into an internal buffer (overwrite or
// accumulate) and, at the end of a group, streams the first N words out as
// single DDR3 write beats at consecutive word addresses.
// Optional feature macro: ALU_WB_SATURATE_EN (saturating accumulation).
module alu_write_back #(
    parameter int N_PIX = 64,
    parameter int DW    = 32,
    parameter int AW    = 27
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic [N_PIX*DW-1:0]   iDATA,
    input  logic                  iACCUM,
    input  logic                  iLAST,
    input  logic [6:0]            iCOUNT,
    input  logic [AW-1:0]         iBASE_ADDR,
    output logic                  oWR_VALID,
    input  logic                  iWR_READY,
    output logic [AW-1:0]         oWR_ADDR,
    output logic [DW-1:0]         oWR_DATA,
    output logic                  oBUSY,
    output logic                  oDONE
);

    localparam int IW = $clog2(N_PIX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Signed DW-bit add: wraps by default, clamps when saturation is enabled.
    function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {a[DW-1], a} + {b[DW-1], b};
`ifdef ALU_WB_SATURATE_EN
        if (sum[DW] != sum[DW-1]) begin
            acc_add = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            acc_add = sum[DW-1:0];
        end
`else
        acc_add = sum[DW-1:0];
`endif
    endfunction

    state_t             state_r, state_nxt_s;
    logic [IW-1:0]      idx_r, idx_nxt_s, idx_inc_s;
    logic [6:0]         cnt_r, cnt_nxt_s, cnt_in_s;
    logic [AW-1:0]      addr_r, addr_nxt_s;
    logic [DW-1:0]      data_r, data_nxt_s;
    logic               valid_r, valid_nxt_s;
    logic               ready_r, ready_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               accept_s;
    logic [DW-1:0]      lane_s [N_PIX];
    logic [DW-1:0]      mem_r  [N_PIX];

    assign accept_s  = iVALID & ready_r;
    assign cnt_in_s  = (iCOUNT > 7'(N_PIX)) ? 7'(N_PIX) : iCOUNT;
    assign idx_inc_s = idx_r + IW'(1);

    assign oREADY    = ready_r;
    assign oWR_VALID = valid_r;
    assign oWR_ADDR  = addr_r;
    assign oWR_DATA  = data_r;
    assign oBUSY     = busy_r;
    assign oDONE     = done_r;

    // Per-lane next buffer value for an accepted result block.
    always_comb begin
        for (int k = 0; k < N_PIX; k++) begin
            if (iACCUM) begin
                lane_s[k] = acc_add(mem_r[k], iDATA[k*DW +: DW]);
            end else begin
                lane_s[k] = iDATA[k*DW +: DW];
            end
        end
    end

    // Result buffer; contents are don't-care after reset so it has no reset.
    always_ff @(posedge iCLK) begin
        if (accept_s) begin
            for (int k = 0; k < N_PIX; k++) begin
                mem_r[k] <= lane_s[k];
            end
        end
    end

    // Next-state and next-output logic; outputs are all registered.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        ready_nxt_s = ready_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && iLAST) begin
                    cnt_nxt_s   = cnt_in_s;
                    idx_nxt_s   = '0;
                    ready_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b1;
                    if (cnt_in_s != 7'd0) begin
                        // First beat comes from the block being captured now.
                        state_nxt_s = ST_FLUSH;
                        valid_nxt_s = 1'b1;
                        addr_nxt_s  = iBASE_ADDR;
                        data_nxt_s  = lane_s[0];
                    end else begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    ready_nxt_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (iWR_READY) begin
                    if (7'(idx_r) == (cnt_r - 7'd1)) begin
                        state_nxt_s = ST_DONE;
                        valid_nxt_s = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        idx_nxt_s   = idx_inc_s;
                        addr_nxt_s  = addr_r + AW'(1);
                        data_nxt_s  = mem_r[idx_inc_s];
                    end
                end else begin
                    // Stalled: hold address and data.
                    valid_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= 7'd0;
            addr_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_write_back.sv
// Directed self-checking bench for alu_write_back with a write-beat scoreboard.
module tb_alu_write_back;

    localparam int N_PIX = 64;
    localparam int DW    = 32;
    localparam int AW    = 27;

    logic                clk = 1'b0;
    logic                rst;
    logic                iVALID, oREADY, iACCUM, iLAST;
    logic [N_PIX*DW-1:0] iDATA;
    logic [6:0]          iCOUNT;
    logic [AW-1:0]       iBASE_ADDR;
    logic                oWR_VALID, iWR_READY;
    logic [AW-1:0]       oWR_ADDR;
    logic [DW-1:0]       oWR_DATA;
    logic                oBUSY, oDONE;

    int vectors = 0;
    int miscompares = 0;
    int beats = 0;

    logic [AW+DW-1:0] sb_q[$];
    logic [AW+DW-1:0] mon_e;
    logic [DW-1:0]    model [N_PIX];
    logic [DW-1:0]    stim  [N_PIX];
    logic             hold = 1'b0;
    logic [AW-1:0]    hold_addr;
    logic [DW-1:0]    hold_data;
    logic [5:0]       bp_pat = 6'b101001;

    alu_write_back #(.N_PIX(N_PIX), .DW(DW), .AW(AW)) dut (
        .iCLK(clk), .iRST(rst), .iVALID(iVALID), .oREADY(oREADY),
        .iDATA(iDATA), .iACCUM(iACCUM), .iLAST(iLAST), .iCOUNT(iCOUNT),
        .iBASE_ADDR(iBASE_ADDR), .oWR_VALID(oWR_VALID), .iWR_READY(iWR_READY),
        .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        logic [63:0] r;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef ALU_WB_SATURATE_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        r = 64'(s);
        return r[DW-1:0];
    endfunction

    // Write-beat monitor: stall stability and in-order scoreboard compare.
    always @(negedge clk) begin
        if (oWR_VALID) begin
            if (hold) begin
                chk("stall_addr", 64'(oWR_ADDR), 64'(hold_addr));
                chk("stall_data", 64'(oWR_DATA), 64'(hold_data));
            end
            if (iWR_READY) begin
                beats++;
                chk("beat_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("wr_addr", 64'(oWR_ADDR), 64'(mon_e[AW+DW-1:DW]));
                    chk("wr_data", 64'(oWR_DATA), 64'(mon_e[DW-1:0]));
                end
                hold = 1'b0;
            end else begin
                hold      = 1'b1;
                hold_addr = oWR_ADDR;
                hold_data = oWR_DATA;
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic send(input logic acc, input logic last, input logic [6:0] cnt, input logic [AW-1:0] base);
        int n;
        iVALID = 1'b1; iACCUM = acc; iLAST = last; iCOUNT = cnt; iBASE_ADDR = base;
        for (int k = 0; k < N_PIX; k++) begin
            iDATA[k*DW +: DW] = stim[k];
            model[k] = acc ? ref_add(model[k], stim[k]) : stim[k];
        end
        if (last) begin
            n = (int'(cnt) > N_PIX) ? N_PIX : int'(cnt);
            for (int k = 0; k < n; k++) sb_q.push_back({base + AW'(k), model[k]});
        end
        @(negedge clk);
        chk("ready_at_handshake", 64'(oREADY), 64'd1);
        @(posedge clk); #1;
        iVALID = 1'b0; iLAST = 1'b0; iACCUM = 1'b0;
    endtask

    task automatic wait_done(input int c, input int pat, input string tag);
        int cyc;
        logic seen;
        seen = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            iWR_READY = (pat == 0) ? 1'b1 : bp_pat[(cyc-1) % 6];
            @(negedge clk);
            if (oDONE) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (pat == 0) chk({tag, "_latency"}, 64'(cyc), 64'(c + 1));
        chk({tag, "_beats"}, 64'(beats), 64'(c));
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({tag, "_busy_in_done"}, 64'(oBUSY), 64'd1);
        @(posedge clk); #1;
        iWR_READY = 1'b1;
        chk({tag, "_ready_after"}, 64'(oREADY), 64'd1);
        chk({tag, "_done_pulse"}, 64'(oDONE), 64'd0);
        beats = 0;
    endtask

    initial begin
        rst = 1'b1; iVALID = 1'b0; iACCUM = 1'b0; iLAST = 1'b0; iCOUNT = 7'd0;
        iBASE_ADDR = '0; iDATA = '0; iWR_READY = 1'b1;
        for (int k = 0; k < N_PIX; k++) model[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", 64'(oWR_VALID), 64'd0);
        chk("rst_wr_addr", 64'(oWR_ADDR), 64'd0);
        chk("rst_wr_data", 64'(oWR_DATA), 64'd0);
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_done", 64'(oDONE), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 64'(oREADY), 64'd1);

        // Overwrite, single beat, full block.
        for (int k = 0; k < N_PIX; k++) stim[k] = DW'(k);
        beats = 0;
        send(1'b0, 1'b1, 7'd64, 27'h100);
        wait_done(64, 0, "overwrite");

        // Accumulate group 5 + 7 - 2, back-to-back.
        for (int k = 0; k < N_PIX; k++) stim[k] = 32'd5;
        send(1'b0, 1'b0, 7'd64, 27'h3000);
        for (int k = 0; k < N_PIX; k++) stim[k] = 32'd7;
        send(1'b1, 1'b0, 7'd64, 27'h3000);
        for (int k = 0; k < N_PIX; k++) stim[k] = 32'hFFFF_FFFE;
        send(1'b1, 1'b1, 7'd64, 27'h3000);
        for (int k = 0; k < N_PIX; k++) chk("accum_model", 64'(model[k]), 64'd10);
        wait_done(64, 0, "accum");

        // Backpressure with an over-range count (clamped to 64).
        for (int k = 0; k < N_PIX; k++) stim[k] = DW'(k);
        send(1'b0, 1'b1, 7'd100, 27'h4000);
        wait_done(64, 1, "backpressure");

        // Pool count of 16.
        for (int k = 0; k < N_PIX; k++) stim[k] = DW'(32'h1000 + k * 3);
        send(1'b0, 1'b1, 7'd16, 27'h2000);
        wait_done(16, 0, "pool");

        // Zero count: no beats, oDONE right after the handshake.
        send(1'b0, 1'b1, 7'd0, 27'h700);
        wait_done(0, 0, "count0");

        // Overflow at both ends of the signed range.
        for (int k = 0; k < N_PIX; k++) stim[k] = (k % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        send(1'b0, 1'b0, 7'd2, 27'h0);
        for (int k = 0; k < N_PIX; k++) stim[k] = (k % 2 == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        send(1'b1, 1'b1, 7'd2, 27'h7FF_FFFF);
`ifdef ALU_WB_SATURATE_EN
        chk("ovf_pos_model", 64'(model[0]), 64'h7FFF_FFFF);
        chk("ovf_neg_model", 64'(model[1]), 64'h8000_0000);
`else
        chk("ovf_pos_model", 64'(model[0]), 64'h8000_0000);
        chk("ovf_neg_model", 64'(model[1]), 64'h7FFF_FFFF);
`endif
        wait_done(2, 0, "overflow");

        // Reset in the middle of a flush.
        for (int k = 0; k < N_PIX; k++) stim[k] = DW'(k + 200);
        send(1'b0, 1'b1, 7'd64, 27'h500);
        for (int i = 0; i < 100; i++) begin
            if (beats >= 10) break;
            @(negedge clk);
        end
        chk("rst_mid_beats", 64'(beats), 64'd10);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(oWR_VALID), 64'd0);
        chk("rst_mid_busy", 64'(oBUSY), 64'd0);
        chk("rst_mid_done", 64'(oDONE), 64'd0);
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 64'(oDONE), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        beats = 0;
        @(posedge clk); #1;
        chk("rst_mid_ready", 64'(oREADY), 64'd1);
        for (int k = 0; k < N_PIX; k++) stim[k] = DW'(k * 3 + 1);
        send(1'b0, 1'b1, 7'd20, 27'h10);
        wait_done(20, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
